// File: rtl/piso_pkg.sv
// Shared types and helpers for the bit-rate PISO shifter family.
// The PAR state exists only when PISO_PARITY_EN is defined.
package piso_pkg;

  localparam logic IDLE_LVL_DEF = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01
`ifdef PISO_PARITY_EN
    ,
    PAR   = 2'b10
`endif
  } state_t;

  // Counter width that stays usable (>=1 bit) even for a divide-by-one.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/br_tick_gen.sv
// Bit-rate divider: tick marks the last clock of each bit period while enabled.
module br_tick_gen import piso_pkg::*; #(
  parameter int CLKS_PER_BIT = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = cnt_width(CLKS_PER_BIT);
  localparam logic [CW-1:0] TERM = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] clk_cnt;

  // Held at zero when idle so every frame starts a fresh full bit period.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_cnt <= '0;
    end else if (!en || clk_cnt == TERM) begin
      clk_cnt <= '0;
    end else begin
      clk_cnt <= clk_cnt + CW'(1);
    end
  end

  assign tick = en && (clk_cnt == TERM);

endmodule

// File: rtl/piso_br_param.sv
// Parametrised PISO with bit-rate divider and busy/done handshake.
// Define PISO_PARITY_EN to append a parity bit (PARITY_ODD selects odd parity).
module piso_br_param import piso_pkg::*; #(
  parameter int DW           = 8,
  parameter int CLKS_PER_BIT = 6,
  parameter bit MSB_FIRST    = 1'b1,
  parameter bit IDLE_LVL     = IDLE_LVL_DEF
`ifdef PISO_PARITY_EN
  ,
  parameter bit PARITY_ODD   = 1'b0
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] din,
  output logic          dout,
  output logic          busy,
  output logic          done
);

  localparam int BW = $clog2(DW + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);

  state_t        state;
  logic [DW-1:0] shreg;
  logic [DW-1:0] shreg_next;
  logic [BW-1:0] bit_cnt;
  logic          tick;
  logic          next_bit;
`ifdef PISO_PARITY_EN
  logic          par_bit;
`endif

  br_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (state != IDLE),
    .tick (tick)
  );

  // The bit that will be on the line after the next shift.
  assign shreg_next = MSB_FIRST ? (shreg << 1) : (shreg >> 1);
  assign next_bit   = MSB_FIRST ? shreg_next[DW-1] : shreg_next[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      dout    <= IDLE_LVL;
      busy    <= 1'b0;
      done    <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
`ifdef PISO_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          dout <= IDLE_LVL;
          busy <= 1'b0;
          if (start) begin
            state   <= SHIFT;
            shreg   <= din;
            bit_cnt <= '0;
            busy    <= 1'b1;
            dout    <= MSB_FIRST ? din[DW-1] : din[0];
`ifdef PISO_PARITY_EN
            par_bit <= (^din) ^ PARITY_ODD;
`endif
          end
        end
        SHIFT: begin
          if (tick) begin
            if (bit_cnt < LAST_BIT) begin
              shreg   <= shreg_next;
              dout    <= next_bit;
              bit_cnt <= bit_cnt + BW'(1);
            end else begin
              bit_cnt <= '0;
`ifdef PISO_PARITY_EN
              state   <= PAR;
              dout    <= par_bit;
`else
              state   <= IDLE;
              busy    <= 1'b0;
              done    <= 1'b1;
              dout    <= IDLE_LVL;
`endif
            end
          end
        end
`ifdef PISO_PARITY_EN
        PAR: begin
          if (tick) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            dout  <= IDLE_LVL;
          end
        end
`endif
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          dout  <= IDLE_LVL;
        end
      endcase
    end
  end

endmodule
